// File: rtl/matvec_sequencer.sv
// matvec_sequencer: walks a weight matrix one row at a time, hands each row and
// the latched input vector to an external dot-product engine, and collects the
// engine results into out_vec. Optional ReLU on captured results is enabled by
// defining MATVEC_RELU_EN; the default build stores results unchanged.
module matvec_sequencer #(
   parameter int FRACTION_WIDTH = 15,
   parameter int BIT_WIDTH      = 32,
   parameter int VECTOR_SIZE    = 10,
   parameter int NUM_ROWS       = 4,
   localparam int ROW_W         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0]  in_vec,
   output logic [ROW_W-1:0]                       row_idx,
   input  logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0]  weight_row,
   output logic                                   dot_start,
   output logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0]  dot_a_vec,
   output logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0]  dot_b_vec,
   input  logic [BIT_WIDTH-1:0]                   dot_result,
   input  logic                                   dot_done,
   output logic [NUM_ROWS-1:0][BIT_WIDTH-1:0]     out_vec,
   output logic                                   busy,
   output logic                                   done
);

   // The fraction width is only carried along for the engine's Q format; a
   // format whose fraction does not fit inside the word is meaningless.
   if (FRACTION_WIDTH >= BIT_WIDTH) begin : g_fracCheck
      $error("matvec_sequencer: FRACTION_WIDTH must be smaller than BIT_WIDTH");
   end

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      CAPTURE,
      FINISH
   } state_t;

   state_t                                state_q, state_d;
   logic [ROW_W-1:0]                      rowIdx_q, rowIdx_d;
   logic                                  prevDotDone_q;
   logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0] aVec_q;
   logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0] bVec_q;
   logic [NUM_ROWS-1:0][BIT_WIDTH-1:0]    outVec_q;
   logic                                  loadA;
   logic                                  loadB;
   logic                                  captureEn;
   logic                                  doneRise;
   logic [BIT_WIDTH-1:0]                  captureWord;

   // Only a fresh low-to-high transition of the engine done level counts, so a
   // level left high by the previous row cannot end the current row early.
   assign doneRise = dot_done & ~prevDotDone_q;

`ifdef MATVEC_RELU_EN
   // Negative results (sign bit set) are clamped to zero before storage.
   assign captureWord = dot_result[BIT_WIDTH-1] ? '0 : dot_result;
`else
   assign captureWord = dot_result;
`endif

   // Next-state and control strobes for the row sequencing FSM.
   always_comb begin
      state_d   = state_q;
      rowIdx_d  = rowIdx_q;
      loadA     = 1'b0;
      loadB     = 1'b0;
      captureEn = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               loadB    = 1'b1;
               rowIdx_d = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            loadA   = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (doneRise) begin
               captureEn = 1'b1;
               state_d   = CAPTURE;
            end
         end
         CAPTURE: begin
            if (rowIdx_q == ROW_W'(NUM_ROWS - 1)) begin
               state_d = FINISH;
            end else begin
               rowIdx_d = rowIdx_q + ROW_W'(1);
               state_d  = LOAD;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, row pointer, operand latches and result storage; reset clears all
   // of it and wins over any request arriving on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         rowIdx_q      <= '0;
         prevDotDone_q <= 1'b0;
         aVec_q        <= '0;
         bVec_q        <= '0;
         outVec_q      <= '0;
      end else begin
         state_q       <= state_d;
         rowIdx_q      <= rowIdx_d;
         prevDotDone_q <= dot_done;
         if (loadB) begin
            bVec_q <= in_vec;
         end
         if (loadA) begin
            aVec_q <= weight_row;
         end
         if (captureEn) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
               if (rowIdx_q == ROW_W'(r)) begin
                  outVec_q[r] <= captureWord;
               end
            end
         end
      end
   end

   assign row_idx   = rowIdx_q;
   assign dot_a_vec = aVec_q;
   assign dot_b_vec = bVec_q;
   assign out_vec   = outVec_q;
   assign busy      = (state_q != IDLE);
   assign dot_start = (state_q == RUN);
   assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_matvec_sequencer.sv
// Testbench for matvec_sequencer: a 4-row instance and a 1-row instance, each
// with a behavioural weight memory and a Q15 dot-product engine whose RUN
// length is programmable. Expected row results go into a queue when a run is
// started and are compared against out_vec when the done pulse appears.
module tb_matvec_sequencer;

   localparam int BW = 32;
   localparam int VS = 10;
   localparam int FW = 15;
   localparam int Q1 = 32768;

   typedef logic [VS-1:0][BW-1:0] vec_t;

   logic clk = 1'b0;
   logic reset;

   logic               start4;
   vec_t               inVec4;
   logic [1:0]         rowIdx4;
   vec_t               weightRow4;
   logic               dotStart4;
   vec_t               dotA4;
   vec_t               dotB4;
   logic [BW-1:0]      dotResult4;
   logic               dotDone4;
   logic [3:0][BW-1:0] outVec4;
   logic               busy4;
   logic               done4;

   logic               start1;
   vec_t               inVec1;
   logic [0:0]         rowIdx1;
   vec_t               weightRow1;
   logic               dotStart1;
   vec_t               dotA1;
   vec_t               dotB1;
   logic [BW-1:0]      dotResult1;
   logic               dotDone1;
   logic [0:0][BW-1:0] outVec1;
   logic               busy1;
   logic               done1;

   vec_t        mem4 [4];
   vec_t        mem1;
   logic        forceDone4 = 1'b0;
   int          doneAt4 = 4;
   int          runCnt4 = 0;
   int          runCnt1 = 0;
   logic [31:0] expQ4[$];
   logic [31:0] expQ1[$];
   int          checks = 0;
   int          errors = 0;

   // Free-running clock.
   always #5 clk = ~clk;

   // Q-format dot product as the external engine computes it.
   function automatic logic [BW-1:0] qdot(input vec_t a, input vec_t b);
      longint acc;
      acc = 0;
      for (int i = 0; i < VS; i++) begin
         acc += (longint'($signed(a[i])) * longint'($signed(b[i]))) >>> FW;
      end
      return acc[BW-1:0];
   endfunction

   function automatic vec_t fill(input int val);
      vec_t v;
      for (int i = 0; i < VS; i++) begin
         v[i] = val;
      end
      return v;
   endfunction

   assign weightRow4 = mem4[rowIdx4];
   assign dotResult4 = qdot(dotA4, dotB4);
   assign dotDone4   = forceDone4 | (dotStart4 && (runCnt4 == doneAt4));

   assign weightRow1 = mem1;
   assign dotResult1 = qdot(dotA1, dotB1);
   assign dotDone1   = dotStart1 && (runCnt1 == 0);

   // Engine models count how long dot_start has been held.
   always @(posedge clk) begin
      runCnt4 <= dotStart4 ? runCnt4 + 1 : 0;
      runCnt1 <= dotStart1 ? runCnt1 + 1 : 0;
   end

   matvec_sequencer #(
      .FRACTION_WIDTH(FW), .BIT_WIDTH(BW), .VECTOR_SIZE(VS), .NUM_ROWS(4)
   ) dut4 (
      .clk(clk), .reset(reset), .start(start4), .in_vec(inVec4),
      .row_idx(rowIdx4), .weight_row(weightRow4), .dot_start(dotStart4),
      .dot_a_vec(dotA4), .dot_b_vec(dotB4), .dot_result(dotResult4),
      .dot_done(dotDone4), .out_vec(outVec4), .busy(busy4), .done(done4)
   );

   matvec_sequencer #(
      .FRACTION_WIDTH(FW), .BIT_WIDTH(BW), .VECTOR_SIZE(VS), .NUM_ROWS(1)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start1), .in_vec(inVec1),
      .row_idx(rowIdx1), .weight_row(weightRow1), .dot_start(dotStart1),
      .dot_a_vec(dotA1), .dot_b_vec(dotB1), .dot_result(dotResult1),
      .dot_done(dotDone1), .out_vec(outVec1), .busy(busy1), .done(done1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one start request to the 4-row instance and queues its results.
   task automatic applyStimulus4(input vec_t v, input logic [3:0][31:0] e, input bit expectResult);
      @(negedge clk);
      inVec4 = v;
      start4 = 1'b1;
      if (expectResult) begin
         for (int r = 0; r < 4; r++) expQ4.push_back(e[r]);
      end
   endtask

   task automatic applyStimulus1(input vec_t v, input logic [31:0] e);
      @(negedge clk);
      inVec1 = v;
      start1 = 1'b1;
      expQ1.push_back(e);
   endtask

   // Watches the 4-row instance for maxCyc cycles after start, optionally
   // re-pulsing start, releasing a held dot_done, or asserting reset mid-run.
   task automatic runDut4(input string name, input int maxCyc, input int restartAt,
                          input int releaseAt, input int resetAt,
                          output int doneCyc, output int donePulses, output int busyCyc,
                          output int firstRunLen, output int maxRow);
      int runState;
      logic [31:0] exp;
      doneCyc = 0; donePulses = 0; busyCyc = 0; firstRunLen = 0; maxRow = 0; runState = 0;
      for (int c = 1; c <= maxCyc; c++) begin
         @(negedge clk);
         if (c == 1 || c == restartAt + 1) start4 = 1'b0;
         if (c == restartAt) begin
            start4 = 1'b1;
            inVec4 = fill(2 * Q1);
         end
         if (c == releaseAt) forceDone4 = 1'b0;
         if (resetAt > 0 && c == resetAt + 1) begin
            checkOutput({name, "_rstBusy"}, 32'(busy4), 32'd0);
            checkOutput({name, "_rstDotStart"}, 32'(dotStart4), 32'd0);
            checkOutput({name, "_rstRowIdx"}, 32'(rowIdx4), 32'd0);
            for (int r = 0; r < 4; r++) begin
               checkOutput($sformatf("%s_rstOut%0d", name, r), outVec4[r], 32'd0);
            end
            reset = 1'b0;
         end
         if (resetAt > 0 && c == resetAt) reset = 1'b1;
         if (busy4) busyCyc++;
         if (runState == 0 && dotStart4) runState = 1;
         if (runState == 1) begin
            if (dotStart4) firstRunLen++;
            else runState = 2;
         end
         if (int'(rowIdx4) > maxRow) maxRow = int'(rowIdx4);
         if (done4) begin
            donePulses++;
            if (doneCyc == 0) doneCyc = c;
            for (int r = 0; r < 4; r++) begin
               if (expQ4.size() > 0) begin
                  exp = expQ4.pop_front();
                  checkOutput($sformatf("%s_out%0d", name, r), outVec4[r], exp);
               end
            end
         end
      end
      expQ4.delete();
   endtask

   initial begin
      vec_t v;
      logic [3:0][31:0] e;
      logic [31:0] exp1;
      int doneCyc, donePulses, busyCyc, firstRunLen, maxRow;

      reset = 1'b1;
      start4 = 1'b1;
      start1 = 1'b1;
      inVec4 = fill(Q1);
      inVec1 = fill(Q1);
      mem1 = fill(Q1 / 4);
      for (int k = 0; k < 4; k++) mem4[k] = fill((k + 1) * Q1);
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy4), 32'd0);
      checkOutput("reset_done", 32'(done4), 32'd0);
      checkOutput("reset_dotStart", 32'(dotStart4), 32'd0);
      checkOutput("reset_rowIdx", 32'(rowIdx4), 32'd0);
      checkOutput("reset_dotA0", dotA4[0], 32'd0);
      checkOutput("reset_dotB0", dotB4[0], 32'd0);
      checkOutput("reset_out3", outVec4[3], 32'd0);
      checkOutput("reset_busy1", 32'(busy1), 32'd0);
      start4 = 1'b0;
      start1 = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Basic run: in_vec all 1.0, row k all (k+1).0, engine R=5.
      $display("[TB] basic four-row run");
      for (int k = 0; k < 4; k++) e[k] = (k + 1) * 10 * Q1;
      applyStimulus4(fill(Q1), e, 1'b1);
      runDut4("basic", 40, 0, 0, 0, doneCyc, donePulses, busyCyc, firstRunLen, maxRow);
      checkOutput("basic_doneCyc", doneCyc, 29);
      checkOutput("basic_donePulses", donePulses, 1);
      checkOutput("basic_busyCyc", busyCyc, 29);
      checkOutput("basic_runLen", firstRunLen, 5);
      checkOutput("basic_maxRow", maxRow, 3);
      checkOutput("basic_rowIdxHold", 32'(rowIdx4), 32'd3);
      checkOutput("basic_busyAfter", 32'(busy4), 32'd0);

      // Start re-pulsed during row 2 with a different vector must be ignored.
      $display("[TB] start during run");
      applyStimulus4(fill(Q1), e, 1'b1);
      runDut4("restart", 60, 17, 0, 0, doneCyc, donePulses, busyCyc, firstRunLen, maxRow);
      checkOutput("restart_doneCyc", doneCyc, 29);
      checkOutput("restart_donePulses", donePulses, 1);
      checkOutput("restart_busyCyc", busyCyc, 29);

      // Signed results through the capture path: row results -3, 2, -0.5, 7.25.
      $display("[TB] signed results");
      v = fill(Q1); v[0] = 32'hFFFE_8000; mem4[0] = v;
      v = fill(Q1); v[0] = 32'h0001_0000; mem4[1] = v;
      v = fill(Q1); v[0] = 32'hFFFF_C000; mem4[2] = v;
      v = fill(Q1); v[0] = 32'h0003_A000; mem4[3] = v;
`ifdef MATVEC_RELU_EN
      e[0] = 32'd0; e[1] = 32'h0001_0000; e[2] = 32'd0; e[3] = 32'h0003_A000;
`else
      e[0] = 32'hFFFE_8000; e[1] = 32'h0001_0000; e[2] = 32'hFFFF_C000; e[3] = 32'h0003_A000;
`endif
      v = fill(0); v[0] = Q1;
      applyStimulus4(v, e, 1'b1);
      runDut4("signed", 40, 0, 0, 0, doneCyc, donePulses, busyCyc, firstRunLen, maxRow);
      checkOutput("signed_doneCyc", doneCyc, 29);

      // Reset in the RUN state of row 1 aborts the run.
      $display("[TB] reset mid-run");
      applyStimulus4(fill(Q1), e, 1'b0);
      runDut4("abort", 40, 0, 0, 10, doneCyc, donePulses, busyCyc, firstRunLen, maxRow);
      checkOutput("abort_donePulses", donePulses, 0);
      checkOutput("abort_busyEnd", 32'(busy4), 32'd0);

      // dot_done already high on RUN entry must not end row 0.
      $display("[TB] stale dot_done");
      doneAt4 = 16;
      forceDone4 = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         mem4[k] = fill((k + 1) * Q1);
         e[k] = (k + 1) * 5 * Q1;
      end
      applyStimulus4(fill(Q1 / 2), e, 1'b1);
      runDut4("stale", 90, 0, 16, 0, doneCyc, donePulses, busyCyc, firstRunLen, maxRow);
      checkOutput("stale_runLen", firstRunLen, 17);
      checkOutput("stale_doneCyc", doneCyc, 77);
      checkOutput("stale_donePulses", donePulses, 1);
      doneAt4 = 4;

      // Single-row instance with a one-cycle engine.
      $display("[TB] single row");
      applyStimulus1(fill(Q1), 32'd81920);
      doneCyc = 0; donePulses = 0; maxRow = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start1 = 1'b0;
         if (int'(rowIdx1) > maxRow) maxRow = int'(rowIdx1);
         if (done1) begin
            donePulses++;
            if (doneCyc == 0) doneCyc = c;
            if (expQ1.size() > 0) begin
               exp1 = expQ1.pop_front();
               checkOutput("single_out0", outVec1[0], exp1);
            end
         end
      end
      checkOutput("single_doneCyc", doneCyc, 4);
      checkOutput("single_donePulses", donePulses, 1);
      checkOutput("single_maxRow", maxRow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matvec_sequencer.md
MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

Interface
REQ-001 The block SHALL have parameter FRACTION_WIDTH, default 15, meaning fractional bits of each Q-format word (passed through only).
REQ-002 The block SHALL have parameter BIT_WIDTH, default 32, meaning width of each data word.
REQ-003 The block SHALL have parameter VECTOR_SIZE, default 10, meaning elements per row and per input vector.
REQ-004 The block SHALL have parameter NUM_ROWS, default 4, meaning rows per matrix and elements of out_vec (minimum 1).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit, meaning a request to begin one matrix-vector product.
REQ-008 The block SHALL have port in_vec, input, BIT_WIDTH x VECTOR_SIZE, meaning the input vector, sampled on the accepted start.
REQ-009 The block SHALL have port row_idx, output, $clog2(NUM_ROWS) bits (minimum 1), meaning the weight-memory row address.
REQ-010 The block SHALL have port weight_row, input, BIT_WIDTH x VECTOR_SIZE, meaning the weight row for row_idx, valid one cycle after row_idx changes.
REQ-011 The block SHALL have port dot_start, output, 1 bit, meaning the start level to the dot-product engine.
REQ-012 The block SHALL have ports dot_a_vec and dot_b_vec, output, BIT_WIDTH x VECTOR_SIZE each, meaning the latched weight row and the latched in_vec.
REQ-013 The block SHALL have port dot_result, input, BIT_WIDTH, meaning the engine result.
REQ-014 The block SHALL have port dot_done, input, 1 bit, meaning the engine done level.
REQ-015 The block SHALL have port out_vec, output, BIT_WIDTH x NUM_ROWS, meaning the captured row results.
REQ-016 The block SHALL have port busy, output, 1 bit, meaning the state is not IDLE.
REQ-017 The block SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN, CAPTURE and FINISH.
REQ-019 In IDLE, start=1 SHALL latch in_vec into dot_b_vec, set row_idx=0 and move to LOAD.
REQ-020 start while not in IDLE SHALL be ignored.
REQ-021 LOAD SHALL last exactly 1 cycle, latch weight_row into dot_a_vec on its final edge, then go to RUN.
REQ-022 In RUN, dot_start SHALL be 1; dot_start SHALL be 0 in every other state.
REQ-023 RUN SHALL exit only on a rising edge of dot_done (dot_done=1 while the registered previous dot_done=0); a dot_done already high on RUN entry SHALL not be taken as completion.
REQ-024 On the RUN exit edge, dot_result SHALL be stored into out_vec[row_idx], and the state SHALL move to CAPTURE.
REQ-025 CAPTURE SHALL last 1 cycle, then: if row_idx==NUM_ROWS-1 go to FINISH, else increment row_idx and go to LOAD.
REQ-026 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 row_idx SHALL never exceed NUM_ROWS-1 and SHALL hold its last value in IDLE.
REQ-028 out_vec SHALL hold its values until overwritten row by row during the next run.
REQ-029 Per-row latency SHALL be 2 + R cycles, where R is the RUN duration including the dot_done edge cycle.
REQ-030 Total start-to-done latency SHALL be 1 + NUM_ROWS*(2+R) cycles.
REQ-031 Result words SHALL be stored bit-exact, with no width change, except as stated in REQ-036.

Reset
REQ-032 Reset SHALL force: state IDLE; dot_start, done and busy to 0; row_idx to 0; the previous-dot_done register to 0; out_vec, dot_a_vec and dot_b_vec to all zero.
REQ-033 Reset asserted mid-run SHALL abort the run within the same edge, with no further out_vec writes and no done pulse.
REQ-034 Reset SHALL take priority over start on the same edge.

Configuration
REQ-035 The macro MATVEC_RELU_EN SHALL control the activation feature.
REQ-036 With MATVEC_RELU_EN defined, a captured dot_result whose MSB (sign) is 1 SHALL be stored as all zero, and all other values stored unchanged.
REQ-037 Without MATVEC_RELU_EN defined, dot_result SHALL be stored unchanged, and no ReLU logic SHALL be present.

Verification
REQ-038 The bench SHALL check: NUM_ROWS=4, engine model with R=5, in_vec all 1.0, row k = all (k+1).0 -> out_vec = {10.0, 20.0, 30.0, 40.0}, done pulse at cycle 29 after start, busy high for cycles 1-29.
REQ-039 The bench SHALL check: dot_done held high from a previous run when RUN is entered -> no capture until dot_done falls and rises again.
REQ-040 The bench SHALL check: start pulsed again during row 2 -> ignored, out_vec unchanged from the first run's values, exactly one done pulse.
REQ-041 The bench SHALL check: reset asserted in the RUN state of row 1 -> next cycle busy=0, dot_start=0, out_vec all zero, no done pulse.
REQ-042 The bench SHALL check: with MATVEC_RELU_EN, row results {-3.0, 2.0} -> out_vec = {0, 2.0}; without it -> out_vec = {-3.0, 2.0}.
REQ-043 The bench SHALL check: NUM_ROWS=1, R=1 -> done at cycle 4 after start, row_idx stays 0 throughout.
